cpu_sequencer: RTL and testbench

Eight-phase control sequencer for the lab CPU datapath. It generates the load enables consumed by the datapath `register` instances (instruction register, accumulator, program counter) and the memory read/write strobes. It decodes the 3-bit opcode held in the instruction register and the accumulator zero flag. It freezes on HLT until reset.

---
 rtl/cpu_sequencer.sv | 152 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: eight-phase control sequencer for the lab CPU datapath.
//
// Walks the phases INST_ADDR..STORE, decoding the IR opcode and the
// accumulator zero flag into register loads and memory strobes. A HLT
// opcode freezes the sequencer in OP_ADDR until reset.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous reset, active-low
//   opcode  in   instruction register opcode (OPW bits)
//   zero    in   accumulator-is-zero flag
//   step    in   single-step advance (only with CPU_SEQ_STEP_EN)
//   sel     out  address mux select (1 = PC, 0 = IR operand)
//   rd      out  memory read strobe
//   ld_ir   out  instruction register load
//   inc_pc  out  PC increment
//   ld_pc   out  PC load (jump)
//   ld_ac   out  accumulator load
//   wr      out  memory write strobe
//   data_e  out  data bus output enable
//   halt    out  CPU halted
//   phase   out  current phase (debug)
//
// Build option: define CPU_SEQ_STEP_EN to add the step port, which gates
// the INST_ADDR -> INST_FETCH transition.
module cpu_sequencer #(
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
`ifdef CPU_SEQ_STEP_EN
    input  logic           step,
`endif
    output logic           sel,
    output logic           rd,
    output logic           ld_ir,
    output logic           inc_pc,
    output logic           ld_pc,
    output logic           ld_ac,
    output logic           wr,
    output logic           data_e,
    output logic           halt,
    output logic [2:0]     phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   is_hlt, is_skz, is_sto, is_jmp, aluop, advance;

    assign is_hlt = opcode == OP_HLT;
    assign is_skz = opcode == OP_SKZ;
    assign is_sto = opcode == OP_STO;
    assign is_jmp = opcode == OP_JMP;
    // ADD, AND, XOR and LDA all read an operand from memory into the ALU
    assign aluop  = opcode inside {3'd2, 3'd3, 3'd4, 3'd5};

`ifdef CPU_SEQ_STEP_EN
    assign advance = (phase_q != INST_ADDR) || step;
`else
    assign advance = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        // the halt freeze wins over everything, including step
        if (!halted_q) begin
            if (phase_q == OP_ADDR && is_hlt) begin
                halted_d = 1'b1;
            end else if (advance) begin
                phase_d = phase_e'(phase_q + 3'd1);
            end
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        phase  = phase_q;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = !is_hlt;
                    halt   = is_hlt;
                end
                OP_FETCH: rd = aluop;
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = is_skz && zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer; expected outputs are
// queued as stimulus is driven and popped when the DUT outputs are sampled.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       step = 1'b0;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;

    int tests = 0;
    int fails = 0;

    logic [2:0]  ph_m = 3'd0;
    logic        h_m  = 1'b0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    cpu_sequencer #(.OPW(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
`ifdef CPU_SEQ_STEP_EN
        .step(step),
`endif
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
        .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
    );

    function automatic logic [11:0] dut_vec();
        return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase};
    endfunction

    // reference: which outputs each phase should raise, written per signal
    function automatic logic [11:0] model(logic [2:0] ph, logic h, logic [2:0] op, logic z);
        logic alu, e_sel, e_rd, e_ir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt;
        alu    = (op >= 3'd2) && (op <= 3'd5);
        e_sel  = !h && ph <= 3'd3;
        e_rd   = !h && ((ph >= 3'd1 && ph <= 3'd3) || (ph >= 3'd5 && alu));
        e_ir   = !h && (ph == 3'd2 || ph == 3'd3);
        e_inc  = !h && ((ph == 3'd4 && op != 3'd0) || (ph == 3'd6 && op == 3'd1 && z));
        e_ldpc = !h && ph >= 3'd6 && op == 3'd7;
        e_ldac = !h && ph == 3'd7 && alu;
        e_wr   = !h && ph == 3'd7 && op == 3'd6;
        e_de   = !h && ph >= 3'd6 && op == 3'd6;
        e_halt = h || (ph == 3'd4 && op == 3'd0);
        return {e_sel, e_rd, e_ir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt, h ? 3'd4 : ph};
    endfunction

    task automatic check(string tag, logic [11:0] got, logic [11:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt phase)",
                     tag, got, exp);
        end
    endtask

    // one clock: drive (at posedge+1), queue expectation, compare at negedge, advance model
    task automatic tick(string tag, logic [2:0] op, logic z, logic st);
        opcode = (ph_m < 3'd4 && !h_m) ? 3'($urandom_range(0, 7)) : op;
        zero   = z;
        step   = st;
        exp_q.push_back(model(ph_m, h_m, opcode, zero));
        @(negedge clk);
        check($sformatf("%s ph%0d", tag, ph_m), dut_vec(), exp_q.pop_front());
        @(posedge clk);
        if (!h_m) begin
            if (ph_m == 3'd4 && opcode == 3'd0) h_m = 1'b1;
`ifdef CPU_SEQ_STEP_EN
            else if (ph_m != 3'd0 || step) ph_m = ph_m + 3'd1;
`else
            else ph_m = ph_m + 3'd1;
`endif
        end
        #1;
    endtask

    task automatic run_instr(string tag, logic [2:0] op, logic z);
        for (int i = 0; i < 8; i++) tick(tag, op, z, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(model(3'd0, 1'b0, 3'd0, 1'b0));
        check("reset", dut_vec(), exp_q.pop_front());
        rst = 1'b1;
        run_instr("add", 3'd2, 1'b0);
        run_instr("add_z", 3'd2, 1'b1);
        run_instr("and", 3'd3, 1'b0);
        run_instr("xor", 3'd4, 1'b1);
        run_instr("lda", 3'd5, 1'b0);
        run_instr("jmp", 3'd7, 1'b1);
        run_instr("sto", 3'd6, 1'b0);
        run_instr("skz1", 3'd1, 1'b1);
        run_instr("skz0", 3'd1, 1'b0);
        for (int i = 0; i < 26; i++) tick("hlt", 3'd0, i[0], 1'b1);
        check("hlt_held", {h_m, ph_m}, 4'b1100);
        // asynchronous reset while halted, checked before any clock edge
        #2 rst = 1'b0;
        #1;
        ph_m = 3'd0;
        h_m  = 1'b0;
        exp_q.push_back(model(3'd0, 1'b0, 3'd0, 1'b0));
        check("async_rst", dut_vec(), exp_q.pop_front());
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_instr("resume_add", 3'd2, 1'b0);
        run_instr("resume_sto", 3'd6, 1'b1);
`ifdef CPU_SEQ_STEP_EN
        for (int i = 0; i < 5; i++) tick("step_hold", 3'd2, 1'b0, 1'b0);
        tick("step_go", 3'd2, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick("step_run", 3'd2, 1'b0, 1'b0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
